rtc_bus_arbiter: RTL and testbench
==================================

RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, maximum cycles a grant is held before forced release (compiled only with RTC_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_i, req_w, req_l  input  1 each  bus requests from initialization, write and read sequencers.
REQ-005 done_i, done_w, done_l  input  1 each  one-cycle end-of-transaction pulses from the matching sequencer.
REQ-006 gnt_i, gnt_w, gnt_l  output  1 each  one-hot bus grants.
REQ-007 a_d_x, cs_x, rd_x, wr_x (x = i, w, l)  input  1 each  RTC bus controls driven by each sequencer.
REQ-008 a_d, cs, rd, wr  output  1 each  arbitrated RTC bus controls.
REQ-009 busy  output  1  high whenever any grant is held or the arbiter is in GAP.
REQ-010 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 States: IDLE, GNT_I, GNT_W, GNT_L, GAP; state held in a registered state variable.
REQ-012 IDLE: sample requests each cycle; fixed priority init > write > read; the next state is the GNT_* of the highest-priority active request; with no request, stay in IDLE.
REQ-013 Grant latency: gnt_* rises exactly one cycle after the first request is sampled in IDLE.
REQ-014 gnt_* is a decode of the state register only; at most one grant is high in any cycle.
REQ-015 GNT_*: hold the grant until the matching done pulse, regardless of req level or higher-priority requests; no preemption.
REQ-016 done for a non-granted requester is ignored.
REQ-017 GNT_* with matching done -> GAP; GAP lasts exactly 1 cycle -> IDLE; requests are not sampled in GAP.
REQ-018 Consequence: back-to-back transactions are separated by at least 2 cycles with the bus idle (GAP plus IDLE).
REQ-019 Bus outputs in a GNT state: a_d/cs/rd/wr pass through combinationally from the granted requester.
REQ-020 Bus outputs in IDLE and GAP: idle level a_d=1, cs=1, rd=1, wr=1.
REQ-021 Fairness: none; read may starve while init or write keep requesting; this behaviour is intended.
REQ-022 busy = (state != IDLE).

Reset
REQ-023 On reset assertion, state goes to IDLE immediately and asynchronously, including mid-transaction.
REQ-024 Reset values: all gnt_*=0, a_d=cs=rd=wr=1, busy=0, timeout=0, watchdog counter=0.
REQ-025 After reset release, the first arbitration occurs on the first rising edge with reset low.

Configuration
REQ-026 Macro: RTC_ARB_TIMEOUT_EN.
REQ-027 When defined, a 10-bit watchdog counter clears on entry to any GNT state and increments each cycle in that state.
REQ-028 When defined and the counter equals TIMEOUT_CYCLES without done, go to GAP and pulse timeout for one cycle.
REQ-029 When defined, a done arriving in the same cycle as the counter limit takes precedence: no timeout pulse.
REQ-030 When undefined, the counter is absent, timeout is tied to 0, and a grant is held indefinitely until done.

Verification
REQ-031 Reset, then req_l=1 at cycle 0 -> gnt_l=1 from cycle 1; bus outputs mirror the *_l inputs; done_l at cycle 5 -> GAP at cycle 6 (gnt_l=0, cs=1) -> IDLE at cycle 7.
REQ-032 req_i=req_w=req_l=1 together in IDLE -> gnt_i first; after done_i -> gnt_w; after done_w -> gnt_l; each grant separated by 2 idle cycles.
REQ-033 During gnt_l, raise req_i; pulse done_i while gnt_l is held -> gnt_l stays high, no state change; gnt_i follows only after done_l plus 2 cycles.
REQ-034 Assert reset mid-GNT_W with wr_w=0 -> gnt_w=0, wr=1 immediately without waiting for a clock edge; busy=0.
REQ-035 With RTC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold req_w with no done -> timeout pulses 8 cycles after grant; GAP, then IDLE, then regrant to w.
REQ-036 With RTC_ARB_TIMEOUT_EN, done_w in the same cycle as the limit -> timeout stays 0; without the macro, a 2000-cycle hold produces no release.

Source files
------------

// File: rtl/rtc_bus_arbiter_if.sv
// Bundle of request/done/grant handshakes and RTC bus control lines shared
// between the three sequencers (init, write, read) and rtc_bus_arbiter.
// The slave modport is the arbiter's view; master is the sequencer side.
interface rtc_bus_arbiter_if;
    logic req_i, req_w, req_l;
    logic done_i, done_w, done_l;
    logic gnt_i, gnt_w, gnt_l;
    logic a_d_i, cs_i, rd_i, wr_i;
    logic a_d_w, cs_w, rd_w, wr_w;
    logic a_d_l, cs_l, rd_l, wr_l;
    logic a_d, cs, rd, wr;
    logic busy, timeout;

    modport slave (
        input  req_i, req_w, req_l,
        input  done_i, done_w, done_l,
        input  a_d_i, cs_i, rd_i, wr_i,
        input  a_d_w, cs_w, rd_w, wr_w,
        input  a_d_l, cs_l, rd_l, wr_l,
        output gnt_i, gnt_w, gnt_l,
        output a_d, cs, rd, wr,
        output busy, timeout
    );

    modport master (
        output req_i, req_w, req_l,
        output done_i, done_w, done_l,
        output a_d_i, cs_i, rd_i, wr_i,
        output a_d_w, cs_w, rd_w, wr_w,
        output a_d_l, cs_l, rd_l, wr_l,
        input  gnt_i, gnt_w, gnt_l,
        input  a_d, cs, rd, wr,
        input  busy, timeout
    );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority (init > write > read), non-preemptive arbiter for the RTC
// bus. A grant is held until the owner's done pulse, followed by one GAP
// cycle and one IDLE cycle before the next grant. Optional grant watchdog
// is compiled in with the macro RTC_ARB_TIMEOUT_EN (parameter TIMEOUT_CYCLES).
module rtc_bus_arbiter
`ifdef RTC_ARB_TIMEOUT_EN
    #(parameter int unsigned TIMEOUT_CYCLES = 1023)
`endif
(
    input  logic                     clk,
    input  logic                     reset,
    rtc_bus_arbiter_if.slave         bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GNT_I = 3'd1,
        ST_GNT_W = 3'd2,
        ST_GNT_L = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   grant_done_s;
    logic   limit_s;
    logic   timeout_s;

    function automatic logic is_gnt(input state_t s);
        return (s == ST_GNT_I) || (s == ST_GNT_W) || (s == ST_GNT_L);
    endfunction

`ifdef RTC_ARB_TIMEOUT_EN
    localparam logic [9:0] WDOG_LIMIT = 10'(TIMEOUT_CYCLES);

    logic [9:0] wdog_q, wdog_d;

    // Watchdog counts cycles spent in one grant; zero on every grant entry.
    always_comb begin
        wdog_d = 10'd0;
        if (is_gnt(state_q) && is_gnt(state_d)) begin
            wdog_d = wdog_q + 10'd1;
        end else begin
            wdog_d = 10'd0;
        end
        limit_s = (wdog_q == WDOG_LIMIT);
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= 10'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // Without the watchdog a grant is only ever ended by its done pulse.
    always_comb begin
        limit_s = 1'b0;
    end
`endif

    // Select the done pulse belonging to the current owner; others are ignored.
    always_comb begin
        grant_done_s = 1'b0;
        case (state_q)
            ST_GNT_I: grant_done_s = bus.done_i;
            ST_GNT_W: grant_done_s = bus.done_w;
            ST_GNT_L: grant_done_s = bus.done_l;
            default:  grant_done_s = 1'b0;
        endcase
    end

    // Next-state logic: arbitrate in IDLE, hold grants until done or watchdog.
    always_comb begin
        state_d   = state_q;
        timeout_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    state_d = ST_GNT_I;
                end else if (bus.req_w) begin
                    state_d = ST_GNT_W;
                end else if (bus.req_l) begin
                    state_d = ST_GNT_L;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_I, ST_GNT_W, ST_GNT_L: begin
                // done wins over a simultaneous watchdog limit
                if (grant_done_s) begin
                    state_d = ST_GAP;
                end else if (limit_s) begin
                    state_d   = ST_GAP;
                    timeout_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset forces IDLE immediately, even mid-transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode: grants from state only, bus muxed from the owner or idle-high.
    always_comb begin
        bus.gnt_i   = 1'b0;
        bus.gnt_w   = 1'b0;
        bus.gnt_l   = 1'b0;
        bus.a_d     = 1'b1;
        bus.cs      = 1'b1;
        bus.rd      = 1'b1;
        bus.wr      = 1'b1;
        case (state_q)
            ST_GNT_I: begin
                bus.gnt_i = 1'b1;
                bus.a_d   = bus.a_d_i;
                bus.cs    = bus.cs_i;
                bus.rd    = bus.rd_i;
                bus.wr    = bus.wr_i;
            end
            ST_GNT_W: begin
                bus.gnt_w = 1'b1;
                bus.a_d   = bus.a_d_w;
                bus.cs    = bus.cs_w;
                bus.rd    = bus.rd_w;
                bus.wr    = bus.wr_w;
            end
            ST_GNT_L: begin
                bus.gnt_l = 1'b1;
                bus.a_d   = bus.a_d_l;
                bus.cs    = bus.cs_l;
                bus.rd    = bus.rd_l;
                bus.wr    = bus.wr_l;
            end
            default: begin
                bus.gnt_i = 1'b0;
            end
        endcase
        bus.busy    = (state_q != ST_IDLE);
        bus.timeout = timeout_s;
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Randomized + directed bench for rtc_bus_arbiter. The reference model tracks
// the current bus owner, grant age and a pending gap as plain integers.
// Build with RTC_ARB_TIMEOUT_EN defined to exercise the watchdog (limit 8).
module tb_rtc_bus_arbiter;

`ifdef RTC_ARB_TIMEOUT_EN
    localparam int TO_LIM = 8;
`else
    localparam int TO_LIM = -1;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rtc_bus_arbiter_if bus_if();

`ifdef RTC_ARB_TIMEOUT_EN
    rtc_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .reset(reset), .bus(bus_if));
`else
    rtc_bus_arbiter dut (.clk(clk), .reset(reset), .bus(bus_if));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: owner -1 = nobody, 0 = init, 1 = write, 2 = read
    int          owner;
    bit          in_gap;
    int          held;
    logic [2:0]  cur_req;
    logic [2:0]  cur_done;
    bit          exp_to;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        in_gap = 1'b0;
        held   = 0;
        exp_to = 1'b0;
    endtask

    // Apply one cycle of inputs at the falling edge and check against the model.
    task automatic drive(input logic [2:0] req, input logic [2:0] dn, input logic [11:0] ctl);
        logic [2:0] exp_gnt;
        logic [3:0] exp_bus;
        @(negedge clk);
        bus_if.req_i  = req[0];  bus_if.req_w  = req[1];  bus_if.req_l  = req[2];
        bus_if.done_i = dn[0];   bus_if.done_w = dn[1];   bus_if.done_l = dn[2];
        {bus_if.a_d_i, bus_if.cs_i, bus_if.rd_i, bus_if.wr_i} = ctl[3:0];
        {bus_if.a_d_w, bus_if.cs_w, bus_if.rd_w, bus_if.wr_w} = ctl[7:4];
        {bus_if.a_d_l, bus_if.cs_l, bus_if.rd_l, bus_if.wr_l} = ctl[11:8];
        cur_req  = req;
        cur_done = dn;
        #1;
        exp_gnt = 3'b000;
        exp_bus = 4'hF;
        exp_to  = 1'b0;
        if (owner >= 0) begin
            exp_gnt = 3'b001 << owner;
            exp_bus = ctl[owner*4 +: 4];
            exp_to  = (TO_LIM > 0) && (held == TO_LIM) && !dn[owner];
        end
        chk_eq("gnt", {29'd0, bus_if.gnt_l, bus_if.gnt_w, bus_if.gnt_i}, {29'd0, exp_gnt});
        chk_eq("bus", {28'd0, bus_if.a_d, bus_if.cs, bus_if.rd, bus_if.wr}, {28'd0, exp_bus});
        chk_eq("busy", {31'd0, bus_if.busy}, {31'd0, (owner >= 0) || in_gap});
        chk_eq("timeout", {31'd0, bus_if.timeout}, {31'd0, exp_to});
    endtask

    // Advance through the rising edge and let the model take the same step.
    task automatic tick();
        @(posedge clk);
        if (owner >= 0) begin
            if (cur_done[owner] || exp_to) begin
                owner  = -1;
                in_gap = 1'b1;
            end else begin
                held++;
            end
        end else if (in_gap) begin
            in_gap = 1'b0;
        end else if (cur_req != 3'b000) begin
            owner = cur_req[0] ? 0 : (cur_req[1] ? 1 : 2);
            held  = 0;
        end
    endtask

    task automatic cyc(input logic [2:0] req, input logic [2:0] dn);
        drive(req, dn, 12'($urandom));
        tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) cyc(3'b000, 3'b111);
    endtask

    task automatic clear_inputs();
        bus_if.req_i = 1'b0;  bus_if.req_w = 1'b0;  bus_if.req_l = 1'b0;
        bus_if.done_i = 1'b0; bus_if.done_w = 1'b0; bus_if.done_l = 1'b0;
        {bus_if.a_d_i, bus_if.cs_i, bus_if.rd_i, bus_if.wr_i} = 4'hF;
        {bus_if.a_d_w, bus_if.cs_w, bus_if.rd_w, bus_if.wr_w} = 4'hF;
        {bus_if.a_d_l, bus_if.cs_l, bus_if.rd_l, bus_if.wr_l} = 4'hF;
    endtask

    initial begin
        logic [11:0] ctl;
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_gnt", {29'd0, bus_if.gnt_l, bus_if.gnt_w, bus_if.gnt_i}, 32'd0);
        chk_eq("rst_bus", {28'd0, bus_if.a_d, bus_if.cs, bus_if.rd, bus_if.wr}, 32'hF);
        chk_eq("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        chk_eq("rst_timeout", {31'd0, bus_if.timeout}, 32'd0);
        reset = 1'b0;

        // single read transaction with explicit cycle timeline
        drive(3'b100, 3'b000, 12'hFFF);
        chk_eq("l_c0_gnt", {31'd0, bus_if.gnt_l}, 32'd0);
        tick();
        ctl = 12'h5A3;
        drive(3'b100, 3'b000, ctl);
        chk_eq("l_c1_gnt", {31'd0, bus_if.gnt_l}, 32'd1);
        chk_eq("l_c1_bus", {28'd0, bus_if.a_d, bus_if.cs, bus_if.rd, bus_if.wr}, 32'h5);
        tick();
        for (int k = 2; k < 5; k++) cyc(3'b100, 3'b000);
        drive(3'b000, 3'b100, 12'h000);
        chk_eq("l_c5_gnt", {31'd0, bus_if.gnt_l}, 32'd1);
        tick();
        drive(3'b000, 3'b000, 12'h000);
        chk_eq("l_c6_gnt", {31'd0, bus_if.gnt_l}, 32'd0);
        chk_eq("l_c6_cs", {31'd0, bus_if.cs}, 32'd1);
        chk_eq("l_c6_busy", {31'd0, bus_if.busy}, 32'd1);
        tick();
        drive(3'b000, 3'b000, 12'h000);
        chk_eq("l_c7_busy", {31'd0, bus_if.busy}, 32'd0);
        tick();

        // all three request together: init, then write, then read
        cyc(3'b111, 3'b000);
        drive(3'b111, 3'b001, 12'h000);
        chk_eq("pri_i", {29'd0, bus_if.gnt_l, bus_if.gnt_w, bus_if.gnt_i}, 32'h1);
        tick();
        cyc(3'b110, 3'b000);
        cyc(3'b110, 3'b000);
        drive(3'b110, 3'b010, 12'h000);
        chk_eq("pri_w", {29'd0, bus_if.gnt_l, bus_if.gnt_w, bus_if.gnt_i}, 32'h2);
        tick();
        cyc(3'b100, 3'b000);
        cyc(3'b100, 3'b000);
        drive(3'b100, 3'b100, 12'h000);
        chk_eq("pri_l", {29'd0, bus_if.gnt_l, bus_if.gnt_w, bus_if.gnt_i}, 32'h4);
        tick();
        drain();

        // no preemption: init request and stray done_i during read grant
        cyc(3'b100, 3'b000);
        cyc(3'b101, 3'b000);
        cyc(3'b101, 3'b001);
        drive(3'b101, 3'b000, 12'h000);
        chk_eq("nopreempt", {29'd0, bus_if.gnt_l, bus_if.gnt_w, bus_if.gnt_i}, 32'h4);
        tick();
        cyc(3'b001, 3'b100);
        cyc(3'b001, 3'b000);
        cyc(3'b001, 3'b000);
        drive(3'b001, 3'b001, 12'h000);
        chk_eq("after_l_gnt_i", {31'd0, bus_if.gnt_i}, 32'd1);
        tick();
        drain();

        // asynchronous reset in the middle of a write grant
        cyc(3'b010, 3'b000);
        drive(3'b010, 3'b000, 12'hF0F);
        chk_eq("pre_rst_wr", {31'd0, bus_if.wr}, 32'd0);
        clear_inputs();
        reset = 1'b1;
        #1;
        chk_eq("arst_gnt_w", {31'd0, bus_if.gnt_w}, 32'd0);
        chk_eq("arst_wr", {31'd0, bus_if.wr}, 32'd1);
        chk_eq("arst_busy", {31'd0, bus_if.busy}, 32'd0);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // long write hold: watchdog release, or indefinite hold without it
        cyc(3'b010, 3'b000);
`ifdef RTC_ARB_TIMEOUT_EN
        for (int k = 0; k <= 8; k++) begin
            drive(3'b010, 3'b000, 12'h000);
            chk_eq("wd_pulse", {31'd0, bus_if.timeout}, {31'd0, k == 8});
            tick();
        end
        cyc(3'b010, 3'b000);
        cyc(3'b010, 3'b000);
        for (int k = 0; k <= 8; k++) begin
            drive(3'b010, {1'b0, k == 8, 1'b0}, 12'h000);
            chk_eq("wd_regrant", {31'd0, bus_if.gnt_w}, 32'd1);
            if (k == 8) chk_eq("wd_done_wins", {31'd0, bus_if.timeout}, 32'd0);
            tick();
        end
`else
        for (int k = 0; k < 2000; k++) cyc(3'b010, 3'b000);
        drive(3'b000, 3'b000, 12'h000);
        chk_eq("hold_2000", {31'd0, bus_if.gnt_w}, 32'd1);
        tick();
`endif
        drain();

        // random traffic against the model
        for (int k = 0; k < 2500; k++) begin
            logic [2:0] rq;
            logic [2:0] dn;
            rq = 3'($urandom);
            dn[0] = ($urandom_range(3, 0) == 0);
            dn[1] = ($urandom_range(3, 0) == 0);
            dn[2] = ($urandom_range(5, 0) == 0);
            cyc(rq, dn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
